// File: rtl/switch_debounce_capture_pkg.sv
// Shared types and defaults for the switch bank input conditioner.
// Imported by the top and the testbench.
package switch_debounce_capture_pkg;

  localparam int DEF_CNT_W = 24;
  localparam logic [DEF_CNT_W-1:0] DEF_DEBOUNCE = 24'd10_000;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

endpackage

// File: rtl/switch_debounce_capture_if.sv
// Valid/ready bundle carrying committed switch words downstream.
// The conditioner drives it as master.
interface switch_debounce_capture_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/switch_debounce_capture_sync2_ff.sv
// Two-flop synchroniser for a word of asynchronous levels.
// Bits are synchronised independently; the debouncer merges them.
module sync2_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_debounce_capture.sv
// Synchronises and debounces the switch word, then offers each
// settled word downstream with edge pulses and an overrun flag.
module switch_debounce_capture
  import switch_debounce_capture_pkg::*;
#(
  parameter int                WIDTH           = 8,
  parameter int                CNT_W           = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = CNT_W'(DEF_DEBOUNCE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             overrun,
  input  logic             overrun_clr,
  switch_debounce_capture_if.master dn
);

  localparam logic [CNT_W-1:0] LAST = DEBOUNCE_CYCLES - CNT_W'(1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic             accept;

  assign accept = dn.out_valid & dn.out_ready;

  sync2_ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sync2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      stable_out   <= '0;
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      dn.out_data  <= '0;
      dn.out_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      if (accept) dn.out_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync2 != stable_out) begin
            cand  <= sync2;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
          end else if (sync2 == stable_out) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            // Later assignments override the accept/clear defaults above.
            stable_out   <= cand;
            rise_pulse   <= cand & ~stable_out;
            fall_pulse   <= ~cand & stable_out;
            dn.out_data  <= cand;
            dn.out_valid <= 1'b1;
            if (dn.out_valid && !dn.out_ready) overrun <= 1'b1;
            state        <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
